// File: rtl/definitions_pkg.sv
// Shared definitions for the gradient window scheduler: frame FSM states and
// default image geometry / pipeline depth.
package definitions_pkg;

    localparam int DEF_IMG_W        = 512;
    localparam int DEF_IMG_H        = 512;
    localparam int DEF_MAX_INFLIGHT = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic accepts_pixels(input state_t s);
        return (s == ST_FILL) || (s == ST_STREAM);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image row of byte storage; the read is combinational so the old value at
// an address is available in the same cycle it gets overwritten.
module line_buffer #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata
);

    logic [7:0] mem_r [DEPTH];

    // Write the accepted byte at the current column
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/gradient_window_scheduler.sv
// Streams raster pixels into two line buffers, issues 3x3 windows to the gradient
// datapath with in-flight credit limiting, and tags returned results with centres.
module gradient_window_scheduler #(
    parameter int IMG_W        = definitions_pkg::DEF_IMG_W,
    parameter int IMG_H        = definitions_pkg::DEF_IMG_H,
    parameter int MAX_INFLIGHT = definitions_pkg::DEF_MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  pix_in,
    input  logic        pix_in_valid,
    output logic        pix_in_ready,
    output logic [71:0] win_data,
    output logic        win_valid,
    input  logic        grad_valid_in,
    output logic [15:0] out_row,
    output logic [15:0] out_col,
    output logic        out_valid,
    output logic        busy,
    output logic        frame_done,
    output logic        err_overflow
);
    import definitions_pkg::*;

    localparam int IFW = $clog2(MAX_INFLIGHT + 1);
    localparam int AW  = $clog2(IMG_W);
    localparam logic [15:0] LAST_COL     = 16'(IMG_W - 1);
    localparam logic [15:0] LAST_ROW     = 16'(IMG_H - 1);
    localparam logic [15:0] RET_LAST_COL = 16'(IMG_W - 3);
    localparam logic [15:0] RET_LAST_ROW = 16'(IMG_H - 3);
    localparam logic [IFW:0] MAX_PEND    = (IFW + 1)'(MAX_INFLIGHT);

    state_t           state_r;
    logic             busy_r;
    logic             frame_done_r;
    logic [15:0]      row_r;
    logic [15:0]      col_r;
    logic [15:0]      ret_row_r;
    logic [15:0]      ret_col_r;
    logic [IFW-1:0]   inflight_r;
    logic             win_valid_r;
    logic             err_r;
    logic [7:0]       tap_r [3][3];
    logic [7:0]       lb1_q_s;
    logic [7:0]       lb2_q_s;
    logic [IFW:0]     pending_s;
    logic             ready_s;
    logic             accept_s;
    logic             ret_s;
    logic             ovf_s;
    logic             fill_end_s;
    logic             last_pix_s;

    // A window already on win_valid still counts against the credit limit
    assign pending_s  = {1'b0, inflight_r} + {{IFW{1'b0}}, win_valid_r};
    assign ready_s    = accepts_pixels(state_r) && (pending_s < MAX_PEND);
    assign accept_s   = pix_in_valid && ready_s;
    assign ret_s      = grad_valid_in && (inflight_r != IFW'(0));
    assign ovf_s      = grad_valid_in && (inflight_r == IFW'(0));
    assign fill_end_s = (row_r == 16'd2) && (col_r == 16'd2);
    assign last_pix_s = (row_r == LAST_ROW) && (col_r == LAST_COL);

    line_buffer #(.DEPTH(IMG_W)) u_lb_prev1 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (col_r[AW-1:0]),
        .wdata (pix_in),
        .rdata (lb1_q_s)
    );

    line_buffer #(.DEPTH(IMG_W)) u_lb_prev2 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (col_r[AW-1:0]),
        .wdata (lb1_q_s),
        .rdata (lb2_q_s)
    );

    // Frame sequencing with registered busy and frame_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    frame_done_r <= 1'b0;
                    if (start) begin
                        state_r <= ST_FILL;
                        busy_r  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept_s && fill_end_s) begin
                        state_r <= last_pix_s ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept_s && last_pix_s) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if ((inflight_r == IFW'(0)) && !win_valid_r) begin
                        state_r      <= ST_DONE;
                        frame_done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Raster position of the next pixel to accept, plus window issue
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r       <= 16'd0;
            col_r       <= 16'd0;
            win_valid_r <= 1'b0;
        end else begin
            win_valid_r <= accept_s && (row_r >= 16'd2) && (col_r >= 16'd2);
            if ((state_r == ST_IDLE) && start) begin
                row_r <= 16'd0;
                col_r <= 16'd0;
            end else if (accept_s) begin
                if (col_r == LAST_COL) begin
                    col_r <= 16'd0;
                    row_r <= (row_r == LAST_ROW) ? 16'd0 : row_r + 16'd1;
                end else begin
                    col_r <= col_r + 16'd1;
                end
            end
        end
    end

    // Sliding 3x3 window; tap row 0 is the oldest line, tap column 0 the leftmost
    always_ff @(posedge clk) begin
        if (accept_s) begin
            for (int k = 0; k < 3; k++) begin
                tap_r[k][0] <= tap_r[k][1];
                tap_r[k][1] <= tap_r[k][2];
            end
            tap_r[0][2] <= lb2_q_s;
            tap_r[1][2] <= lb1_q_s;
            tap_r[2][2] <= pix_in;
        end
    end

    // In-flight credits, returned-result centre tracking and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= IFW'(0);
            ret_row_r  <= 16'd0;
            ret_col_r  <= 16'd0;
            err_r      <= 1'b0;
        end else begin
            if (win_valid_r && !ret_s) begin
                inflight_r <= inflight_r + IFW'(1);
            end else if (!win_valid_r && ret_s) begin
                inflight_r <= inflight_r - IFW'(1);
            end
            if (ovf_s) begin
                err_r <= 1'b1;
            end
            if (ret_s) begin
                if (ret_col_r == RET_LAST_COL) begin
                    ret_col_r <= 16'd0;
                    ret_row_r <= (ret_row_r == RET_LAST_ROW) ? 16'd0 : ret_row_r + 16'd1;
                end else begin
                    ret_col_r <= ret_col_r + 16'd1;
                end
            end else if ((state_r == ST_IDLE) && start) begin
                ret_row_r <= 16'd0;
                ret_col_r <= 16'd0;
            end
        end
    end

    // Pack the taps so byte i is window row i/3, column i%3
    always_comb begin
        win_data = 72'd0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                win_data[(3 * k + j) * 8 +: 8] = tap_r[k][j];
            end
        end
    end

    assign win_valid    = win_valid_r;
    assign pix_in_ready = ready_s;
    assign out_valid    = grad_valid_in;
    assign out_row      = ret_row_r + 16'd1;
    assign out_col      = ret_col_r + 16'd1;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;
    assign err_overflow = err_r;

endmodule

// File: tb/tb_gradient_window_scheduler.sv
// Bench for gradient_window_scheduler: a 5x4 image, one instance with default
// credits and one with two credits, checked against an image-level window model.
module tb_gradient_window_scheduler;

    localparam int W      = 5;
    localparam int H      = 4;
    localparam int NWIN   = (W - 2) * (H - 2);
    localparam int BUDGET = 400;

    logic        clk = 1'b0;
    logic        rst, start, pix_in_valid, grad_valid_in, sel;
    logic [7:0]  pix_in;

    logic        ready_a, win_valid_a, out_valid_a, busy_a, done_a, err_a;
    logic        ready_b, win_valid_b, out_valid_b, busy_b, done_b, err_b;
    logic [71:0] win_data_a, win_data_b;
    logic [15:0] out_row_a, out_col_a, out_row_b, out_col_b;

    logic        ready_s, win_valid_s, out_valid_s, busy_s, done_s, err_s;
    logic [71:0] win_data_s;
    logic [15:0] out_row_s, out_col_s;

    logic [7:0]  img_m [W * H];
    logic [71:0] first_win;
    bit          exp_err;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    gradient_window_scheduler #(.IMG_W(W), .IMG_H(H), .MAX_INFLIGHT(8)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .pix_in(pix_in),
        .pix_in_valid(pix_in_valid & ~sel), .pix_in_ready(ready_a),
        .win_data(win_data_a), .win_valid(win_valid_a),
        .grad_valid_in(grad_valid_in & ~sel), .out_row(out_row_a), .out_col(out_col_a),
        .out_valid(out_valid_a), .busy(busy_a), .frame_done(done_a), .err_overflow(err_a)
    );

    gradient_window_scheduler #(.IMG_W(W), .IMG_H(H), .MAX_INFLIGHT(2)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .pix_in(pix_in),
        .pix_in_valid(pix_in_valid & sel), .pix_in_ready(ready_b),
        .win_data(win_data_b), .win_valid(win_valid_b),
        .grad_valid_in(grad_valid_in & sel), .out_row(out_row_b), .out_col(out_col_b),
        .out_valid(out_valid_b), .busy(busy_b), .frame_done(done_b), .err_overflow(err_b)
    );

    assign ready_s     = sel ? ready_b     : ready_a;
    assign win_valid_s = sel ? win_valid_b : win_valid_a;
    assign win_data_s  = sel ? win_data_b  : win_data_a;
    assign out_valid_s = sel ? out_valid_b : out_valid_a;
    assign out_row_s   = sel ? out_row_b   : out_row_a;
    assign out_col_s   = sel ? out_col_b   : out_col_a;
    assign busy_s      = sel ? busy_b      : busy_a;
    assign done_s      = sel ? done_b      : done_a;
    assign err_s       = sel ? err_b       : err_a;

    // k-th window in raster order of centres, built straight from the image
    function automatic logic [71:0] exp_window(input int k);
        logic [71:0] w;
        int r, c;
        r = 1 + k / (W - 2);
        c = 1 + k % (W - 2);
        w = 72'd0;
        for (int i = 0; i < 9; i++) w[i * 8 +: 8] = img_m[(r - 1 + i / 3) * W + (c - 1 + i % 3)];
        return w;
    endfunction

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (busy_s !== 1'b0 || win_valid_s !== 1'b0 || done_s !== 1'b0 || ready_s !== 1'b0)
        begin
            errors++;
            $display("FAIL %s: busy=%b win_valid=%b frame_done=%b ready=%b, required all 0",
                     tag, busy_s, win_valid_s, done_s, ready_s);
        end
        checks++;
        if (out_row_s !== 16'd1 || out_col_s !== 16'd1) begin
            errors++;
            $display("FAIL %s_centre: got (%0d,%0d) required (1,1)", tag, out_row_s, out_col_s);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; pix_in_valid = 1'b0; grad_valid_in = 1'b0;
        #1;
        checks++;
        if (win_valid_s !== 1'b0) begin
            errors++;
            $display("FAIL abort_window: win_valid=%b required 0", win_valid_s);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset_state");
        checks++;
        if (err_s !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b required 0", err_s);
        end
    endtask

    // One frame: start, stream pixels with random gaps, return results after lat cycles
    task automatic run_frame(input int valid_pct, input int lat, input int hold,
                             input int abort_at, input bit ramp);
        int pi, wi, ri, cyc, last_ret, last_push, mx, t;
        bit done_seen;
        int ret_q[$];
        pi = 0; wi = 0; ri = 0; cyc = 0; last_ret = 0; last_push = 0; done_seen = 1'b0;
        mx = sel ? 2 : 8;
        for (int i = 0; i < W * H; i++) img_m[i] = ramp ? 8'(10 * (i / W) + (i % W)) : 8'($urandom);
        while (!done_seen && cyc < BUDGET) begin
            @(negedge clk);
            start = (cyc == 0) ? 1'b1 : ($urandom_range(0, 15) == 0);
            pix_in_valid = (cyc > 0) && (pi < W * H) && ($urandom_range(1, 100) <= valid_pct);
            pix_in = pix_in_valid ? img_m[pi] : 8'($urandom);
            grad_valid_in = (ret_q.size() > 0) && (ret_q[0] == cyc);
            if (grad_valid_in) void'(ret_q.pop_front());
            #1;
            if (win_valid_s) begin
                checks++;
                if (wi >= NWIN) begin
                    errors++;
                    $display("FAIL extra_window: got window %0d required at most %0d", wi + 1, NWIN);
                end else if (win_data_s !== exp_window(wi)) begin
                    errors++;
                    $display("FAIL win_data[%0d]: got %h required %h", wi, win_data_s, exp_window(wi));
                end
                if (wi == 0) first_win = win_data_s;
                t = cyc + lat;
                if (t < hold) t = hold;
                if (t <= last_push) t = last_push + 1;
                ret_q.push_back(t);
                last_push = t;
                wi++;
            end
            checks++;
            if ((wi - ri) > mx || ((wi - ri) == mx && ready_s !== 1'b0)) begin
                errors++;
                $display("FAIL credit_limit: outstanding=%0d ready=%b, limit %0d requires ready 0",
                         wi - ri, ready_s, mx);
            end
            checks++;
            if (out_valid_s !== grad_valid_in) begin
                errors++;
                $display("FAIL out_valid: got %b required %b", out_valid_s, grad_valid_in);
            end
            if (grad_valid_in) begin
                checks++;
                if (out_row_s !== 16'(1 + ri / (W - 2)) || out_col_s !== 16'(1 + ri % (W - 2))) begin
                    errors++;
                    $display("FAIL centre[%0d]: got (%0d,%0d) required (%0d,%0d)", ri,
                             out_row_s, out_col_s, 1 + ri / (W - 2), 1 + ri % (W - 2));
                end
                ri++;
                last_ret = cyc;
            end
            checks++;
            if (busy_s !== (cyc > 0)) begin
                errors++;
                $display("FAIL busy: got %b required %b at cycle %0d", busy_s, cyc > 0, cyc);
            end
            if (cyc <= 1) begin
                checks++;
                if (ready_s !== (cyc == 1)) begin
                    errors++;
                    $display("FAIL ready_start: got %b required %b at cycle %0d", ready_s, cyc == 1, cyc);
                end
            end
            checks++;
            if (err_s !== exp_err) begin
                errors++;
                $display("FAIL err_overflow: got %b required %b", err_s, exp_err);
            end
            if (done_s) begin
                done_seen = 1'b1;
                checks++;
                if (cyc != last_ret + 2 || wi != NWIN || ri != NWIN) begin
                    errors++;
                    $display("FAIL frame_done: cycle %0d windows %0d results %0d, required cycle %0d, %0d and %0d",
                             cyc, wi, ri, last_ret + 2, NWIN, NWIN);
                end
            end
            if (pix_in_valid && ready_s) pi++;
            if (abort_at > 0 && pi == abort_at) break;
            cyc++;
        end
        if (abort_at == 0) begin
            checks++;
            if (!done_seen) begin
                errors++;
                $display("FAIL frame_timeout: no frame_done in %0d cycles (windows %0d results %0d)",
                         BUDGET, wi, ri);
            end
            @(negedge clk);
            start = 1'b0; pix_in_valid = 1'b0; grad_valid_in = 1'b0;
            #1;
            checks++;
            if (busy_s !== 1'b0 || done_s !== 1'b0) begin
                errors++;
                $display("FAIL after_done: busy=%b frame_done=%b required 0 0", busy_s, done_s);
            end
        end
    endtask

    task automatic test_reset();
        sel = 1'b0; rst = 1'b1; start = 1'b0; pix_in_valid = 1'b0; grad_valid_in = 1'b0; pix_in = 8'd0;
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset_a");
        sel = 1'b1;
        #1;
        check_idle_outputs("reset_b");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_frame();
        run_frame(100, 4, 0, 0, 1'b1);
        checks++;
        if (first_win !== 72'h16_15_14_0C_0B_0A_02_01_00) begin
            errors++;
            $display("FAIL first_window: got %h required 161514_0c0b0a_020100", first_win);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 4; n++) run_frame($urandom_range(40, 100), $urandom_range(1, 6), 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        run_frame(100, 3, 40, 0, 1'b1);
        run_frame(70, 2, 0, 0, 1'b0);
        sel = 1'b0;
    endtask

    task automatic test_abort();
        run_frame(100, 4, 0, 12, 1'b1);
        pulse_reset();
        run_frame(100, 4, 0, 0, 1'b0);
    endtask

    task automatic test_overflow();
        @(negedge clk);
        grad_valid_in = 1'b1;
        #1;
        checks++;
        if (out_valid_s !== 1'b1) begin
            errors++;
            $display("FAIL idle_out_valid: got %b required 1", out_valid_s);
        end
        @(negedge clk);
        grad_valid_in = 1'b0;
        #1;
        checks++;
        if (err_s !== 1'b1 || out_row_s !== 16'd1 || out_col_s !== 16'd1) begin
            errors++;
            $display("FAIL overflow: err=%b centre (%0d,%0d) required err 1 centre (1,1)",
                     err_s, out_row_s, out_col_s);
        end
        exp_err = 1'b1;
        run_frame(80, 2, 0, 0, 1'b0);
        exp_err = 1'b0;
        pulse_reset();
    endtask

    task automatic test_back_to_back();
        run_frame(100, 1, 0, 0, 1'b0);
        run_frame(100, 1, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_frame();
        test_random_frames();
        test_backpressure();
        test_abort();
        test_overflow();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gradient_window_scheduler.md
GRADIENT_WINDOW_SCHEDULER -- requirements
Module: gradient_window_scheduler

Interface
REQ-001 Parameter IMG_W, default 512, pixels per image row (>=3).
REQ-002 Parameter IMG_H, default 512, rows per frame (>=3).
REQ-003 Parameter MAX_INFLIGHT, default 8, maximum windows issued but not yet returned from the gradient pipeline.
REQ-004 Port clk, input, 1, single clock; all logic on rising edge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port start, input, 1, single-cycle request to begin a frame.
REQ-007 Port pix_in, input, 8, raster-order pixel; pix_in_valid, input, 1; pix_in_ready, output, 1.
REQ-008 Port win_data, output, 72, 3x3 window to gradient datapath; win_valid, output, 1.
REQ-009 Port grad_valid_in, input, 1, result-valid returned by gradient datapath.
REQ-010 Ports out_row and out_col, output, 16 each, centre coordinate of the current returned result; out_valid, output, 1.
REQ-011 Ports busy, output, 1; frame_done, output, 1 (pulse); err_overflow, output, 1 (sticky).

Function
REQ-012 FSM states: IDLE, FILL, STREAM, DRAIN, DONE.
REQ-013 IDLE->FILL on start; start in any other state is ignored.
REQ-014 FILL: accept pixels until row 2, col 2 is accepted, then STREAM; no windows issued in FILL.
REQ-015 STREAM->DRAIN after pixel (IMG_H-1, IMG_W-1) is accepted.
REQ-016 DRAIN->DONE when inflight==0; DONE->IDLE unconditionally after one cycle, frame_done=1 only in DONE.
REQ-017 busy=1 in every state except IDLE.
REQ-018 pix_in_ready=1 in FILL/STREAM when inflight<MAX_INFLIGHT, else 0; transfer occurs only when valid and ready both high.
REQ-019 Row/col counters advance per accepted pixel; col wraps IMG_W-1->0 and increments row.
REQ-020 Two row buffers of IMG_W bytes hold rows r-1 and r-2; written at the accepted column.
REQ-021 Window issued when the accepted pixel has row>=2 and col>=2; centre = (row-1, col-1).
REQ-022 win_data byte i (bits i*8+7:i*8) = pixel at window row i/3 (0 = oldest row), window col i%3 (0 = leftmost).
REQ-023 win_valid asserts exactly one cycle after the accepting cycle, for one cycle per window.
REQ-024 Border positions (row 0, row IMG_H-1, col 0, col IMG_W-1 as centre) never issue windows; frame issues exactly (IMG_H-2)*(IMG_W-2) windows.
REQ-025 inflight increments on win_valid and decrements on grad_valid_in; when both occur in the same cycle, inflight is unchanged.
REQ-026 Returned-result counter tracks out_row/out_col: starts at (1,1); col runs 1..IMG_W-2 and wraps to 1 with row+1.
REQ-027 out_valid equals grad_valid_in in the same cycle; out_row/out_col are valid when out_valid=1.
REQ-028 grad_valid_in with inflight==0 sets err_overflow and leaves counters unchanged; err_overflow clears only on rst.
REQ-029 Counter arithmetic is unsigned; inflight width is $clog2(MAX_INFLIGHT+1).

Reset
REQ-030 rst (sampled on clk) returns FSM to IDLE and zeroes row, col, inflight, and the return counter; it also clears win_valid, out_valid, frame_done, busy, pix_in_ready, and err_overflow.
REQ-031 Row buffer contents are not reset; no window is issued after reset until FILL completes again.
REQ-032 rst asserted mid-frame aborts the frame; no frame_done pulse and no window issued in the following cycle.

Structure
REQ-033 The FSM state enum and default IMG_W/IMG_H/MAX_INFLIGHT constants reside in definitions_pkg.
REQ-034 The row buffers are implemented as one sub-module, line_buffer (parameter depth; one write port and one read port, same address), instantiated twice.

Verification
REQ-035 IMG_W=5, IMG_H=4, 20 pixels back-to-back, grad_valid_in returned 4 cycles after each win_valid -> exactly 6 windows, centres (1,1)..(1,3),(2,1)..(2,3), then one frame_done pulse.
REQ-036 Pixel value = 10*row+col, IMG_W=5 -> first window bytes 0..8 = 0,1,2,10,11,12,20,21,22.
REQ-037 MAX_INFLIGHT=2, grad_valid_in withheld -> pix_in_ready=0 after the second window; the first return restores ready and the stream completes correctly.
REQ-038 rst asserted after 12 accepted pixels, then start -> no windows until the new FILL completes; the full frame matches REQ-035.
REQ-039 grad_valid_in pulsed in IDLE -> err_overflow=1 and held until rst; start while busy -> no effect.
REQ-040 win_valid and grad_valid_in in the same cycle with inflight=1 -> inflight remains 1.
